casex_code_encoder: RTL and testbench

//  Transmit-side encoder for the (a,b) -> (c,d) casex decode interface: takes

---
 rtl/casex_code_encoder.sv | 103 ++++++++++
 tb/tb_casex_code_encoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/casex_code_encoder.sv
// casex_code_encoder
// Encodes requested (c,d) result codes into the (a,b) stimulus word for the
// casex decoder and queues the words in a small FIFO. Unencodable requests
// are consumed, flagged with a one-cycle err pulse and counted.
module casex_code_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_c,
    input  logic             in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a,
    output logic [2:0]       b,
    output logic             err,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [3:0]       mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             enc_ok;
    logic             enc_a;
    logic [2:0]       enc_b;
    logic [3:0]       head;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_ok;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign a         = empty ? 1'b0 : head[3];
    assign b         = empty ? 3'b000 : head[2:0];

    // Request encoder: maps (in_d, in_c) to the (a,b) word or flags it unencodable.
    always_comb begin
        enc_ok = 1'b1;
        enc_a  = 1'b0;
        enc_b  = 3'b000;
        if (in_d) begin
            enc_b = 3'b100;
        end else begin
            case (in_c)
                3'b010:  enc_b = 3'b001;
                3'b011:  begin enc_a = 1'b1; enc_b = 3'b110; end
                3'b000:  enc_b = 3'b111;
                default: enc_ok = 1'b0;
            endcase
        end
    end

    // FIFO storage and pointers; reset discards every queued word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PTR_W-1:0]] <= {enc_a, enc_b};
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Error pulse and saturating delivery / drop counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err      <= 1'b0;
            sent_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            err <= accept && !enc_ok;
            if (pop && (sent_cnt != '1)) begin
                sent_cnt <= sent_cnt + CNT_W'(1);
            end
            if (accept && !enc_ok && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_casex_code_encoder.sv
// Self-checking bench for casex_code_encoder: table vectors, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_casex_code_encoder;

    localparam int DEPTH = 4;
    localparam int SAT   = 255;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_c;
    logic       in_d;
    logic       out_valid;
    logic       out_ready;
    logic       a;
    logic [2:0] b;
    logic       err;
    logic [7:0] sent_cnt;
    logic [7:0] err_cnt;

    // second instance with narrow counters for saturation checks
    logic       in_valid2;
    logic       in_ready2;
    logic [2:0] in_c2;
    logic       in_d2;
    logic       out_valid2;
    logic       out_ready2;
    logic       a2;
    logic [2:0] b2;
    logic       err2;
    logic [1:0] sent_cnt2;
    logic [1:0] err_cnt2;

    casex_code_encoder #(.DEPTH(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b),
        .err(err), .sent_cnt(sent_cnt), .err_cnt(err_cnt)
    );

    casex_code_encoder #(.DEPTH(4), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_c(in_c2), .in_d(in_d2),
        .out_valid(out_valid2), .out_ready(out_ready2), .a(a2), .b(b2),
        .err(err2), .sent_cnt(sent_cnt2), .err_cnt(err_cnt2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [3:0] q[$];
    int  m_sent;
    int  m_errs;
    bit  m_err;

    typedef struct {
        logic       d;
        logic [2:0] c;
        bit         ok;
        logic       ea;
        logic [2:0] eb;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding rules written straight from the code table.
    function automatic bit ref_enc(input bit d, input int c, output logic [3:0] w);
        w = 4'b0000;
        if (d) begin w = 4'b0100; return 1'b1; end
        if (c == 2) begin w = 4'b0001; return 1'b1; end
        if (c == 3) begin w = 4'b1110; return 1'b1; end
        if (c == 0) begin w = 4'b0111; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        q.delete();
        m_sent = 0;
        m_errs = 0;
        m_err  = 1'b0;
    endtask

    // Advance the model over one rising edge with the given inputs.
    task automatic model_step(input bit iv, input int c, input bit d, input bit ordy);
        logic [3:0] w;
        bit ok;
        bit acc;
        acc = iv && (q.size() < DEPTH);
        ok  = ref_enc(d, c, w);
        if (ordy && q.size() > 0) begin
            void'(q.pop_front());
            m_sent = sat(m_sent + 1, SAT);
        end
        m_err = acc && !ok;
        if (acc && ok) q.push_back(w);
        if (acc && !ok) m_errs = sat(m_errs + 1, SAT);
    endtask

    task automatic check_all(input string tag);
        logic [3:0] hw;
        hw = (q.size() > 0) ? q[0] : 4'b0000;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
        chk({tag, ".a"},         32'(a),         32'(hw[3]));
        chk({tag, ".b"},         32'(b),         32'(hw[2:0]));
        chk({tag, ".err"},       32'(err),       32'(m_err));
        chk({tag, ".sent_cnt"},  32'(sent_cnt),  32'(m_sent));
        chk({tag, ".err_cnt"},   32'(err_cnt),   32'(m_errs));
    endtask

    // Drive inputs at a falling edge, pass one rising edge, check at the next falling edge.
    task automatic cycle(input string tag, input bit iv, input int c, input bit d, input bit ordy);
        in_valid  = iv;
        in_c      = 3'(c);
        in_d      = d;
        out_ready = ordy;
        model_step(iv, c, d, ordy);
        @(negedge clock);
        check_all(tag);
    endtask

    initial begin
        vecs[0]  = '{d:1'b0, c:3'd0, ok:1'b1, ea:1'b0, eb:3'b111};
        vecs[1]  = '{d:1'b0, c:3'd1, ok:1'b0, ea:1'b0, eb:3'b000};
        vecs[2]  = '{d:1'b0, c:3'd2, ok:1'b1, ea:1'b0, eb:3'b001};
        vecs[3]  = '{d:1'b0, c:3'd3, ok:1'b1, ea:1'b1, eb:3'b110};
        vecs[4]  = '{d:1'b0, c:3'd4, ok:1'b0, ea:1'b0, eb:3'b000};
        vecs[5]  = '{d:1'b0, c:3'd5, ok:1'b0, ea:1'b0, eb:3'b000};
        vecs[6]  = '{d:1'b0, c:3'd6, ok:1'b0, ea:1'b0, eb:3'b000};
        vecs[7]  = '{d:1'b0, c:3'd7, ok:1'b0, ea:1'b0, eb:3'b000};
        vecs[8]  = '{d:1'b1, c:3'd0, ok:1'b1, ea:1'b0, eb:3'b100};
        vecs[9]  = '{d:1'b1, c:3'd3, ok:1'b1, ea:1'b0, eb:3'b100};
        vecs[10] = '{d:1'b1, c:3'd5, ok:1'b1, ea:1'b0, eb:3'b100};
        vecs[11] = '{d:1'b1, c:3'd7, ok:1'b1, ea:1'b0, eb:3'b100};

        in_valid = 0; in_c = 0; in_d = 0; out_ready = 0;
        in_valid2 = 0; in_c2 = 0; in_d2 = 0; out_ready2 = 0;
        reset = 1'b0;
        model_clear();
        #1;
        check_all("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // table vectors, one request at a time from an empty FIFO
        for (int i = 0; i < 12; i++) begin
            cycle("vec", 1'b1, int'(vecs[i].c), vecs[i].d, 1'b1);
            if (vecs[i].ok) begin
                chk("vec.tbl_valid", 32'(out_valid), 32'd1);
                chk("vec.tbl_a",     32'(a),         32'(vecs[i].ea));
                chk("vec.tbl_b",     32'(b),         32'(vecs[i].eb));
            end else begin
                chk("vec.tbl_err",   32'(err),       32'd1);
                chk("vec.tbl_valid", 32'(out_valid), 32'd0);
            end
            cycle("vec_drain", 1'b0, 0, 1'b0, 1'b1);
            chk("vec.tbl_err_clr", 32'(err), 32'd0);
        end
        chk("vec.sent_total", 32'(sent_cnt), 32'd7);
        chk("vec.err_total",  32'(err_cnt),  32'd5);

        // backpressure: four pushes fill the FIFO, fifth request is held
        cycle("bp", 1'b1, 5, 1'b1, 1'b0);
        cycle("bp", 1'b1, 2, 1'b0, 1'b0);
        cycle("bp", 1'b1, 3, 1'b0, 1'b0);
        cycle("bp", 1'b1, 0, 1'b0, 1'b0);
        chk("bp.full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold", 1'b1, 2, 1'b0, 1'b0);
            chk("bp.hold_b", 32'(b), 32'b100);
        end
        begin
            logic [2:0] order [4];
            order[0] = 3'b100; order[1] = 3'b001; order[2] = 3'b110; order[3] = 3'b111;
            for (int i = 0; i < 4; i++) begin
                chk("bp.drain_b", 32'(b), 32'(order[i]));
                cycle("bp_drain", 1'b0, 0, 1'b0, 1'b1);
            end
        end
        chk("bp.empty", 32'(out_valid), 32'd0);

        // three entries, simultaneous push and pop for ten cycles
        cycle("pp_fill", 1'b1, 0, 1'b1, 1'b0);
        cycle("pp_fill", 1'b1, 2, 1'b0, 1'b0);
        cycle("pp_fill", 1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle("pp", 1'b1, (i % 2 == 0) ? 0 : 3, 1'(i % 3 == 0), 1'b1);
            chk("pp.occupancy", 32'(q.size()), 32'd3);
        end
        for (int i = 0; i < 3; i++) cycle("pp_drain", 1'b0, 0, 1'b0, 1'b1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle("rand", $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        end

        // asynchronous reset with three queued words
        cycle("rst_fill", 1'b0, 0, 1'b0, 1'b1);
        cycle("rst_fill", 1'b0, 0, 1'b0, 1'b1);
        cycle("rst_fill", 1'b0, 0, 1'b0, 1'b1);
        cycle("rst_fill", 1'b1, 3, 1'b0, 1'b0);
        cycle("rst_fill", 1'b1, 2, 1'b0, 1'b0);
        cycle("rst_fill", 1'b1, 0, 1'b1, 1'b0);
        chk("rst.pre_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_all("rst_async");
        @(negedge clock);
        reset = 1'b1;
        cycle("rst_after", 1'b1, 2, 1'b0, 1'b1);
        chk("rst.first_b", 32'(b), 32'b001);
        cycle("rst_after", 1'b0, 0, 1'b0, 1'b1);
        chk("rst.sent_one", 32'(sent_cnt), 32'd1);

        // narrow-counter instance: sent_cnt saturates at 3
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_d2 = 1'b1;
        in_c2 = 3'd0;
        out_ready2 = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            int e;
            in_valid2 = (n <= 5);
            @(negedge clock);
            e = ((n < 6) ? n : 6) - 1;
            chk("sat.sent_cnt2", 32'(sent_cnt2), 32'(sat(e, 3)));
        end
        // narrow-counter instance: err_cnt saturates at 3
        in_d2 = 1'b0;
        in_c2 = 3'd5;
        for (int k = 1; k <= 5; k++) begin
            in_valid2 = 1'b1;
            @(negedge clock);
            chk("sat.err2", 32'(err2), 32'd1);
            chk("sat.err_cnt2", 32'(err_cnt2), 32'(sat(k, 3)));
        end
        in_valid2 = 1'b0;
        @(negedge clock);
        chk("sat.err2_clr", 32'(err2), 32'd0);
        chk("sat.sent_hold", 32'(sent_cnt2), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
